// File: rtl/photo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : photo_pkg                                                      |
// | Shared types and constants for the photo capture controller: FSM state   |
// | encoding, fault codes, requester indices and a one-hot helper.           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package photo_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT    = 3'd2,
    ACK     = 3'd3,
    RECOVER = 3'd4
  } state_t;

  localparam logic [1:0] FAULT_NONE = 2'b00;
  localparam logic [1:0] FAULT_ERR  = 2'b01;
  localparam logic [1:0] FAULT_TMO  = 2'b10;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_BTN = 1'b1;

  // Requester index -> one-hot bit in a 2-bit per-requester vector.
  function automatic logic [1:0] onehot2(input logic idx);
    return (idx == REQ_CPU) ? 2'b01 : 2'b10;
  endfunction

endpackage
`default_nettype wire

// File: rtl/photo_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : photo_rr_arb                                                   |
// | 2-way round-robin arbiter. Combinational grant from the pending bits and |
// | the last owner; the owner register updates when a grant is taken.       |
// | Ports   : clk, reset (async active-low), pend[1:0], grant_en (grant is   |
// |           consumed this cycle), grant_valid, grant_idx, owner.          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module photo_rr_arb
  import photo_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] pend,
  input  logic       grant_en,
  output logic       grant_valid,
  output logic       grant_idx,
  output logic       owner
);

  always_comb begin
    grant_valid = |pend;
    grant_idx   = REQ_CPU;
    if (pend == 2'b11) begin
      // Both waiting: the one that did not go last wins.
      grant_idx = ~owner;
    end else if (pend[REQ_BTN]) begin
      grant_idx = REQ_BTN;
    end
  end

  // Resetting to the button makes the CPU win the first contended grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner <= REQ_BTN;
    end else if (grant_en && grant_valid) begin
      owner <= grant_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/photo_capture_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : photo_capture_ctrl                                             |
// | Sequencer/arbiter in front of the single-frame capture SM. Queues CPU   |
// | and button snapshot requests, grants them round-robin, runs the          |
// | start/ack handshake and recovers the capture SM on error or timeout.    |
// | Ports   : clk, reset (async active-low), req[1:0], req_done[1:0],       |
// |           req_err[1:0], cap_start, cap_ack, cap_rst_n, cap_done,        |
// |           cap_error, busy, owner, frame_count[CNT_W-1:0], fault,        |
// |           fault_code[1:0], fault_clr.                                   |
// | Config  : PHOTO_CTRL_WDT_EN - builds the WAIT watchdog (timeout after   |
// |           TIMEOUT_CYCLES WAIT cycles -> RECOVER, fault_code 10).        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module photo_capture_ctrl
  import photo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int RST_CYCLES     = 4,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  output logic [1:0]       req_done,
  output logic [1:0]       req_err,
  output logic             cap_start,
  output logic             cap_ack,
  output logic             cap_rst_n,
  input  logic             cap_done,
  input  logic             cap_error,
  output logic             busy,
  output logic             owner,
  output logic [CNT_W-1:0] frame_count,
  output logic             fault,
  output logic [1:0]       fault_code,
  input  logic             fault_clr
);

  localparam int RC_W = (RST_CYCLES > 2) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

  state_t          state, state_nxt;
  logic [1:0]      pend;
  logic [1:0]      rec_code;
  logic            grant_en, grant_valid, grant_idx;
  logic            timeout;
  logic [RC_W-1:0] rcnt;
  logic            rcnt_last;
  logic            enter_rec;

  photo_rr_arb u_arb (
    .clk         (clk),
    .reset       (reset),
    .pend        (pend),
    .grant_en    (grant_en),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .owner       (owner)
  );

`ifdef PHOTO_CTRL_WDT_EN
  localparam int WDT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(TIMEOUT_CYCLES - 1);
  logic [WDT_W-1:0] wdt;

  // Cleared in START, counts only in WAIT, saturates at the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdt <= '0;
    end else if (state == START) begin
      wdt <= '0;
    end else if (state == WAIT && wdt != WDT_LAST) begin
      wdt <= wdt + 1'b1;
    end
  end

  assign timeout = (state == WAIT) && (wdt == WDT_LAST);
`else
  // No watchdog: WAIT leaves only on done or error. TIMEOUT_CYCLES must be
  // positive in either build.
  if (TIMEOUT_CYCLES > 0) begin : g_wdt_off
    assign timeout = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rec_code  = FAULT_NONE;
    grant_en  = 1'b0;
    case (state)
      IDLE: begin
        // A done still high from the previous capture blocks a new start.
        if (grant_valid && !cap_done) begin
          grant_en  = 1'b1;
          state_nxt = START;
        end
      end
      START: state_nxt = WAIT;
      WAIT: begin
        if (cap_error) begin
          state_nxt = RECOVER;
          rec_code  = FAULT_ERR;
        end else if (cap_done) begin
          state_nxt = ACK;
        end else if (timeout) begin
          state_nxt = RECOVER;
          rec_code  = FAULT_TMO;
        end
      end
      ACK: state_nxt = IDLE;
      RECOVER: begin
        if (rcnt_last) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = RECOVER;
        rec_code  = FAULT_ERR;
      end
    endcase
  end

  // A request in its own grant cycle is absorbed by the grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend <= 2'b00;
    end else begin
      pend <= (pend | req) & ~(grant_en ? onehot2(grant_idx) : 2'b00);
    end
  end

  // rcnt is zero on the first RECOVER cycle, which also times req_err.
  assign rcnt_last = (rcnt == RC_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rcnt <= '0;
    end else if (state != RECOVER) begin
      rcnt <= '0;
    end else if (!rcnt_last) begin
      rcnt <= rcnt + 1'b1;
    end
  end

  assign enter_rec = (state_nxt == RECOVER) && (state != RECOVER);

  // A new fault outranks a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault      <= 1'b0;
      fault_code <= FAULT_NONE;
    end else if (enter_rec) begin
      fault      <= 1'b1;
      fault_code <= rec_code;
    end else if (fault_clr) begin
      fault      <= 1'b0;
      fault_code <= FAULT_NONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_count <= '0;
    end else if (state == ACK) begin
      frame_count <= frame_count + 1'b1;
    end
  end

  assign busy      = (state != IDLE);
  assign cap_start = (state == START);
  assign cap_ack   = (state == ACK);
  assign cap_rst_n = (state != RECOVER);
  assign req_done  = (state == ACK) ? onehot2(owner) : 2'b00;
  assign req_err   = (state == RECOVER && rcnt == '0) ? onehot2(owner) : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_photo_capture_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_photo_capture_ctrl                                          |
// | Directed self-checking bench for photo_capture_ctrl (CNT_W=2,           |
// | TIMEOUT_CYCLES=50, RST_CYCLES=4). Honours PHOTO_CTRL_WDT_EN.            |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_photo_capture_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] req_done, req_err;
  logic       cap_start, cap_ack, cap_rst_n;
  logic       cap_done = 1'b0;
  logic       cap_error = 1'b0;
  logic       busy, owner;
  logic [1:0] frame_count;
  logic       fault;
  logic [1:0] fault_code;
  logic       fault_clr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int n_start = 0;
  int n_ack = 0;
  int n_err = 0;

  photo_capture_ctrl #(
    .TIMEOUT_CYCLES (50),
    .RST_CYCLES     (4),
    .CNT_W          (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_done    (req_done),
    .req_err     (req_err),
    .cap_start   (cap_start),
    .cap_ack     (cap_ack),
    .cap_rst_n   (cap_rst_n),
    .cap_done    (cap_done),
    .cap_error   (cap_error),
    .busy        (busy),
    .owner       (owner),
    .frame_count (frame_count),
    .fault       (fault),
    .fault_code  (fault_code),
    .fault_clr   (fault_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cap_start)  n_start++;
    if (cap_ack)    n_ack++;
    if (|req_err)   n_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick;
    tick;
    reset = 1'b1;
  endtask

  // Pulse req for one edge; the grant edge follows, leaving the DUT in START.
  task automatic request(input logic [1:0] r, input string tag);
    req = r;
    tick;
    req = 2'b00;
    tick;
    check({tag, "_start"}, cap_start, 1'b1);
  endtask

  // Called in START. Leaves the DUT in IDLE with cap_done low again.
  task automatic capture(input int lat, output logic [1:0] done_seen, output logic ack_seen);
    tick;
    repeat (lat - 1) tick;
    cap_done = 1'b1;
    tick;
    done_seen = req_done;
    ack_seen  = cap_ack;
    tick;
    cap_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [1:0] d;
    logic       a;
    int         s0, a0, e0, n;
    int         exp_fc [5];
    exp_fc = '{1, 2, 3, 0, 1};

    // Reset state.
    do_reset;
    check("rst_hs", {cap_start, cap_ack, cap_rst_n, busy}, 4'b0010);
    check("rst_pulses", {req_done, req_err}, 4'b0000);
    check("rst_owner", owner, 1'b1);
    check("rst_fc", frame_count, 2'd0);
    check("rst_fault", {fault, fault_code}, 3'b000);

    // Single request, done 100 cycles after start.
    s0 = n_start; a0 = n_ack;
    request(2'b01, "t1");
    check("t1_owner", owner, 1'b0);
    capture(100, d, a);
    check("t1_done", d, 2'b01);
    check("t1_ack", a, 1'b1);
    check("t1_fc", frame_count, 2'd1);
    check("t1_nstart", n_start - s0, 1);
    check("t1_nack", n_ack - a0, 1);
    check("t1_idle", busy, 1'b0);

    // Contention: CPU first, then button.
    do_reset;
    request(2'b11, "t2a");
    check("t2a_owner", owner, 1'b0);
    capture(5, d, a);
    check("t2a_done", d, 2'b01);
    tick;
    check("t2b_start", cap_start, 1'b1);
    check("t2b_owner", owner, 1'b1);
    capture(5, d, a);
    check("t2b_done", d, 2'b10);
    check("t2_fc", frame_count, 2'd2);

    // Capture error together with done and fault_clr: error and set win.
    request(2'b01, "t3");
    tick;
    tick;
    e0 = n_err;
    cap_error = 1'b1; cap_done = 1'b1; fault_clr = 1'b1;
    tick;
    cap_error = 1'b0; cap_done = 1'b0; fault_clr = 1'b0;
    check("t3_rst_n", cap_rst_n, 1'b0);
    check("t3_ack", cap_ack, 1'b0);
    check("t3_err", req_err, 2'b01);
    check("t3_fault", {fault, fault_code}, 3'b101);
    n = 0;
    while (!cap_rst_n && n < 20) begin
      n++;
      tick;
    end
    check("t3_rst_len", n, 4);
    check("t3_nerr", n_err - e0, 1);
    check("t3_idle", busy, 1'b0);
    check("t3_fc", frame_count, 2'd2);
    check("t3_sticky", fault, 1'b1);
    fault_clr = 1'b1;
    tick;
    fault_clr = 1'b0;
    check("t3_clr", {fault, fault_code}, 3'b000);

    // Timeout: cap_done never returned.
    request(2'b10, "t4");
    check("t4_owner", owner, 1'b1);
    n = 0;
    while (cap_rst_n && n < 200) begin
      tick;
      n++;
    end
`ifdef PHOTO_CTRL_WDT_EN
    // 50 WAIT cycles, then RECOVER: 51 edges from the START cycle.
    check("t4_tmo_at", n, 51);
    check("t4_code", {fault, fault_code}, 3'b110);
    check("t4_err", req_err, 2'b10);
    n = 0;
    while (!cap_rst_n && n < 20) begin
      n++;
      tick;
    end
    check("t4_rst_len", n, 4);
`else
    check("t4_stay", n, 200);
    check("t4_busy", busy, 1'b1);
    check("t4_nofault", {fault, fault_code}, 3'b000);
    cap_done = 1'b1;
    tick;
    check("t4_ack", cap_ack, 1'b1);
    tick;
    cap_done = 1'b0;
`endif

    // Reset in WAIT with the button request queued.
    do_reset;
    request(2'b01, "t5");
    tick;
    req = 2'b10;
    tick;
    req = 2'b00;
    check("t5_in_wait", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("t5_hs", {cap_start, cap_ack, cap_rst_n, busy}, 4'b0010);
    check("t5_pulses", {req_done, req_err}, 4'b0000);
    check("t5_owner", owner, 1'b1);
    check("t5_fault", {fault, fault_code, frame_count}, 5'b00000);
    #2;
    reset = 1'b1;
    s0 = n_start;
    repeat (5) tick;
    check("t5_no_pend", busy, 1'b0);
    check("t5_nstart", n_start - s0, 0);

    // frame_count wrap with CNT_W=2.
    for (int i = 0; i < 5; i++) begin
      request(2'b01, "t6");
      capture(3, d, a);
      check("t6_fc", frame_count, exp_fc[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
